keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Matrix-keypad reader for the 4x4 keypad on the board.
- Drives `columnas` one-hot, samples `filas_raw` and debounces both press and release.
- Emits one key code per physical press, with a single-cycle valid strobe.
- Sits between the keypad pins and the digit/display logic in `module_top`, and is the counterpart to the bench that drives `filas_raw` in response to `columnas`.

Parameters:
- `SCAN_CYCLES`, default 27000: clock cycles each column is driven before advancing (1 ms at 27 MHz). Must be >= 2.
- `DEBOUNCE_CYCLES`, default 270000: consecutive stable cycles required to accept a press or a release (10 ms). Must be >= 1.

Ports:
- `clk` input 1: 27 MHz system clock.
- `rst_n` input 1: asynchronous active-low reset.
- `filas_raw` input 4: raw keypad rows, asynchronous, active-high (bit r = row r).
- `columnas` output 4: one-hot active-high column drive (bit c = column c).
- `key_code` output 4: code of the last accepted key; held until the next accept.
- `key_valid` output 1: one-cycle pulse when `key_code` updates.
- `key_pressed` output 1: level, high while an accepted key has not yet been debounced as released.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - `columnas`=0001, `key_code`=0, `key_valid`=0, `key_pressed`=0.
  - State SCAN, all counters 0, synchronizer flops 0.
- Row synchronization:
  - `filas_raw` passes through a 2-FF synchronizer; `rows_s` is the output.
  - Only `rows_s` is used internally, so there are 2 cycles of input latency.
- State SCAN:
  - `scan_cnt` counts 0..SCAN_CYCLES-1 while the current column is driven.
  - When `scan_cnt`==SCAN_CYCLES-1, the block evaluates `rows_s`:
    - Exactly one bit set: capture row index r and column index c, clear `db_cnt`, go to DEBOUNCE. The column is NOT advanced.
    - Zero bits or more than one bit set (ghosting or multi-press): rotate the column 0001->0010->0100->1000->0001, `scan_cnt`=0, stay in SCAN.
- State DEBOUNCE:
  - The column is held.
  - Each cycle `rows_s` equals the captured one-hot pattern, `db_cnt` increments.
  - On any mismatch: return to SCAN, advance the column, clear both counters, emit no output.
  - When `db_cnt` reaches DEBOUNCE_CYCLES-1 with a match:
    - Next cycle: `key_code`=map(r,c), `key_valid`=1 for that one cycle, `key_pressed`=1.
    - Go to HOLD.
  - So `key_valid` rises exactly DEBOUNCE_CYCLES cycles after DEBOUNCE is entered.
- State HOLD:
  - The column is held and `key_pressed`=1.
  - When `rows_s`==0000: clear `db_cnt`, go to RELEASE.
  - A change to a different nonzero pattern is ignored, giving one key per press.
- State RELEASE:
  - The column is held.
  - Any nonzero `rows_s` returns to HOLD.
  - `db_cnt` counts consecutive all-zero cycles. At DEBOUNCE_CYCLES-1: `key_pressed`=0, advance the column, `scan_cnt`=0, go to SCAN.
- Key map (row r, column c):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: *, 0, #, D
  - Codes are digits 0x0-0x9, A-D 0xA-0xD, * 0xE, # 0xF.
- Counter widths are `$clog2` of the respective parameter; counters never wrap past their terminal value.
- Reset asserted mid-operation forces the reset values immediately. No `key_valid` is emitted for a press interrupted by reset.
- `key_valid` never asserts in two consecutive cycles.

Decomposition:
- Package `keypad_pkg`:
  - `state_t` enum {SCAN, DEBOUNCE, HOLD, RELEASE}.
  - Key code constants `KEY_STAR`=4'hE and `KEY_HASH`=4'hF.
  - Function `key_map(row_idx, col_idx)` returning the 4-bit code.
  - Function `onehot4_to_idx`.
- One sub-module, `sync_2ff` (parameterized width, async active-low reset), instantiated for the rows.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8):
- Reset: `rst_n`=0 mid-scan -> `columnas`=0001, `key_valid`=0, `key_code`=0, `key_pressed`=0 immediately; after release `columnas` rotates every 4 cycles through 0001, 0010, 0100, 1000, 0001.
- Clean press: model key "6" (row1, col2) asserts `filas_raw`=0010 while `columnas`=0100 and holds it -> `columnas` freezes at 0100, `key_valid` pulses once with `key_code`=0x6, `key_pressed`=1.
- Bounce: row toggles for 3 cycles then stabilizes -> no `key_valid` during the bounce; exactly one pulse after 8 stable cycles.
- Long hold: key "#" (row3, col2) held 100 cycles -> exactly one `key_valid` (code 0xF). Release with a 2-cycle glitch -> `key_pressed` stays 1 until 8 consecutive zero cycles, then scanning resumes from 1000.
- Multi-row: `filas_raw`=0011 in a column -> no capture, column keeps advancing, `key_valid` stays 0.
- Full map sweep: press each of the 16 keys in turn -> `key_code` sequence matches the map, including D=0xD at row3, col3.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// Key codes follow the board layout: digits as-is, A-D as 0xA-0xD, '*' 0xE, '#' 0xF.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_HASH;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] onehot4_to_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for asynchronous level inputs (the keypad rows).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad reader: scans columns one-hot, debounces press and release,
// and reports one key code per physical press with a single-cycle strobe.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 27000,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] filas_raw,
    output logic [3:0] columnas,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    state_t            r_state;
    logic [3:0]        r_col;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [DB_W-1:0]   r_db_cnt;
    logic [3:0]        r_row_pat;
    logic [1:0]        r_row_idx;
    logic [1:0]        r_col_idx;
    logic [3:0]        r_key_code;
    logic              r_key_valid;
    logic              r_key_pressed;
    logic [3:0]        w_rows_s;
    logic [3:0]        w_col_next;

    sync_2ff #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (filas_raw),
        .o_q   (w_rows_s)
    );

    assign w_col_next = {r_col[2:0], r_col[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= SCAN;
            r_col         <= 4'b0001;
            r_scan_cnt    <= '0;
            r_db_cnt      <= '0;
            r_row_pat     <= 4'b0000;
            r_row_idx     <= 2'd0;
            r_col_idx     <= 2'd0;
            r_key_code    <= 4'h0;
            r_key_valid   <= 1'b0;
            r_key_pressed <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (r_scan_cnt == SCAN_LAST) begin
                        // Ghosting/multi-press patterns are skipped rather than guessed at.
                        if (is_onehot4(w_rows_s)) begin
                            r_row_pat <= w_rows_s;
                            r_row_idx <= onehot4_to_idx(w_rows_s);
                            r_col_idx <= onehot4_to_idx(r_col);
                            r_db_cnt  <= '0;
                            r_state   <= DEBOUNCE;
                        end else begin
                            r_col      <= w_col_next;
                            r_scan_cnt <= '0;
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (w_rows_s == r_row_pat) begin
                        if (r_db_cnt == DB_LAST) begin
                            r_key_code    <= key_map(r_row_idx, r_col_idx);
                            r_key_valid   <= 1'b1;
                            r_key_pressed <= 1'b1;
                            r_state       <= HOLD;
                        end else begin
                            r_db_cnt <= r_db_cnt + 1'b1;
                        end
                    end else begin
                        r_col      <= w_col_next;
                        r_scan_cnt <= '0;
                        r_db_cnt   <= '0;
                        r_state    <= SCAN;
                    end
                end
                HOLD: begin
                    if (w_rows_s == 4'b0000) begin
                        r_db_cnt <= '0;
                        r_state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (w_rows_s != 4'b0000) begin
                        r_state <= HOLD;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_key_pressed <= 1'b0;
                        r_col         <= w_col_next;
                        r_scan_cnt    <= '0;
                        r_db_cnt      <= '0;
                        r_state       <= SCAN;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign columnas    = r_col;
    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_pressed = r_key_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_CYCLES=4, DEBOUNCE_CYCLES=8.
// A keypad model drives the rows from the column drive; overrides inject glitches.
module tb_keypad_scanner;

    typedef struct {
        logic [1:0] row;
        logic [1:0] col;
        logic [3:0] exp_code;
        logic [3:0] exp_col;
        logic [3:0] exp_next_col;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] filas_raw;
    logic [3:0] columnas;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;

    logic       key_down;
    logic [1:0] key_row;
    logic [1:0] key_col;
    logic       ovr_en;
    logic [3:0] ovr;

    int   n_checks;
    int   n_errors;
    int   valid_cnt;
    logic prev_valid;

    vec_t       vecs[16];
    int         cyc;
    int         cyc2;
    bit         ok;
    int         v0;
    logic [3:0] exp_col;
    logic [3:0] prev_col;
    logic [4:0] bounce_pat;

    keypad_scanner #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .filas_raw   (filas_raw),
        .columnas    (columnas),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // keypad model: a pressed key connects its row to its column
    always_comb begin
        if (ovr_en)
            filas_raw = ovr;
        else if (key_down && columnas[key_col])
            filas_raw = 4'b0001 << key_row;
        else
            filas_raw = 4'b0000;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // valid-strobe monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (key_valid) begin
                valid_cnt++;
                check("valid_not_back_to_back", {31'd0, prev_valid}, 32'd0);
            end
            prev_valid = key_valid;
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] col, input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (columnas == col) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int max, output int n, output bit found);
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (key_valid) begin
                found = 1'b1;
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_release(input int max, output int n, output bit found);
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (!key_pressed) begin
                found = 1'b1;
                n = i;
                break;
            end
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        key_row  = r;
        key_col  = c;
        key_down = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{2'd0, 2'd0, 4'h1, 4'b0001, 4'b0010};
        vecs[1]  = '{2'd0, 2'd1, 4'h2, 4'b0010, 4'b0100};
        vecs[2]  = '{2'd0, 2'd2, 4'h3, 4'b0100, 4'b1000};
        vecs[3]  = '{2'd0, 2'd3, 4'hA, 4'b1000, 4'b0001};
        vecs[4]  = '{2'd1, 2'd0, 4'h4, 4'b0001, 4'b0010};
        vecs[5]  = '{2'd1, 2'd1, 4'h5, 4'b0010, 4'b0100};
        vecs[6]  = '{2'd1, 2'd2, 4'h6, 4'b0100, 4'b1000};
        vecs[7]  = '{2'd1, 2'd3, 4'hB, 4'b1000, 4'b0001};
        vecs[8]  = '{2'd2, 2'd0, 4'h7, 4'b0001, 4'b0010};
        vecs[9]  = '{2'd2, 2'd1, 4'h8, 4'b0010, 4'b0100};
        vecs[10] = '{2'd2, 2'd2, 4'h9, 4'b0100, 4'b1000};
        vecs[11] = '{2'd2, 2'd3, 4'hC, 4'b1000, 4'b0001};
        vecs[12] = '{2'd3, 2'd0, 4'hE, 4'b0001, 4'b0010};
        vecs[13] = '{2'd3, 2'd1, 4'h0, 4'b0010, 4'b0100};
        vecs[14] = '{2'd3, 2'd2, 4'hF, 4'b0100, 4'b1000};
        vecs[15] = '{2'd3, 2'd3, 4'hD, 4'b1000, 4'b0001};

        n_checks   = 0;
        n_errors   = 0;
        valid_cnt  = 0;
        prev_valid = 1'b0;
        key_down   = 1'b0;
        key_row    = 2'd0;
        key_col    = 2'd0;
        ovr_en     = 1'b0;
        ovr        = 4'b0000;
        rst_n      = 1'b0;

        // reset values and column rotation
        tick(3);
        check("rst_columnas", columnas, 4'b0001);
        check("rst_key_code", key_code, 4'h0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_pressed", key_pressed, 1'b0);
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            exp_col = 4'b0001 << ((i / 4) % 4);
            check("scan_rotation", columnas, exp_col);
        end
        tick(5);
        check("pre_reset_columnas", columnas, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_columnas", columnas, 4'b0001);
        check("async_rst_key_valid", key_valid, 1'b0);
        check("async_rst_key_pressed", key_pressed, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // clean press of '6' (row1, col2)
        wait_col(4'b0001, 40, ok);
        check("clean_wait_col0", ok, 1'b1);
        press(2'd1, 2'd2);
        v0 = valid_cnt;
        wait_col(4'b0100, 40, ok);
        check("clean_wait_col2", ok, 1'b1);
        wait_valid(40, cyc, ok);
        check("clean_valid_seen", ok, 1'b1);
        check("clean_valid_latency", cyc, 12);
        check("clean_key_code", key_code, 4'h6);
        check("clean_key_pressed", key_pressed, 1'b1);
        check("clean_columnas_frozen", columnas, 4'b0100);
        tick(10);
        check("clean_single_pulse", valid_cnt - v0, 1);
        key_down = 1'b0;
        wait_release(40, cyc, ok);
        check("clean_release_seen", ok, 1'b1);
        check("clean_resume_col", columnas, 4'b1000);

        // bouncing press of '5' (row1, col1)
        wait_col(4'b0001, 40, ok);
        check("bounce_wait_col0", ok, 1'b1);
        wait_col(4'b0010, 40, ok);
        check("bounce_wait_col1", ok, 1'b1);
        v0 = valid_cnt;
        press(2'd1, 2'd1);
        bounce_pat = 5'b10101;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("bounce_no_valid", key_valid, 1'b0);
            key_down = bounce_pat[k-1];
        end
        wait_valid(60, cyc, ok);
        check("bounce_valid_seen", ok, 1'b1);
        check("bounce_valid_latency", cyc + 5, 29);
        check("bounce_key_code", key_code, 4'h5);
        tick(5);
        check("bounce_single_pulse", valid_cnt - v0, 1);
        key_down = 1'b0;
        wait_release(40, cyc, ok);
        check("bounce_release_seen", ok, 1'b1);

        // long hold of '#' (row3, col2), then a glitchy release
        v0 = valid_cnt;
        press(2'd3, 2'd2);
        wait_valid(60, cyc, ok);
        check("hold_valid_seen", ok, 1'b1);
        check("hold_key_code", key_code, 4'hF);
        tick(50);
        ovr_en = 1'b1;
        ovr    = 4'b0011;
        tick(5);
        ovr_en = 1'b0;
        tick(45);
        check("hold_single_pulse", valid_cnt - v0, 1);
        check("hold_key_pressed", key_pressed, 1'b1);
        check("hold_columnas", columnas, 4'b0100);
        key_down = 1'b0;
        tick(4);
        check("release_pre_glitch_pressed", key_pressed, 1'b1);
        ovr_en = 1'b1;
        ovr    = 4'b1000;
        tick(2);
        ovr_en = 1'b0;
        wait_release(40, cyc, ok);
        check("release_seen", ok, 1'b1);
        check("release_latency_after_glitch", cyc, 11);
        check("release_resume_col", columnas, 4'b1000);
        check("release_no_extra_valid", valid_cnt - v0, 1);

        // multi-row pattern never captures
        v0 = valid_cnt;
        ovr_en = 1'b1;
        ovr    = 4'b0011;
        prev_col = columnas;
        for (int k = 0; k < 8; k++) begin
            tick(4);
            exp_col = {prev_col[2:0], prev_col[3]};
            check("multirow_rotation", columnas, exp_col);
            prev_col = columnas;
        end
        ovr_en = 1'b0;
        check("multirow_no_valid", valid_cnt - v0, 0);
        check("multirow_not_pressed", key_pressed, 1'b0);

        // reset in the middle of debouncing '1'
        press(2'd0, 2'd0);
        wait_col(4'b1000, 40, ok);
        check("rstmid_wait_col3", ok, 1'b1);
        wait_col(4'b0001, 40, ok);
        check("rstmid_wait_col0", ok, 1'b1);
        tick(7);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_key_code", key_code, 4'h0);
        check("rstmid_key_valid", key_valid, 1'b0);
        check("rstmid_key_pressed", key_pressed, 1'b0);
        check("rstmid_columnas", columnas, 4'b0001);
        key_down = 1'b0;
        v0 = valid_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        tick(30);
        check("rstmid_no_valid", valid_cnt - v0, 0);

        // full keypad sweep
        for (int i = 0; i < 16; i++) begin
            v0 = valid_cnt;
            press(vecs[i].row, vecs[i].col);
            wait_valid(80, cyc, ok);
            check("sweep_valid_seen", ok, 1'b1);
            check("sweep_key_code", key_code, vecs[i].exp_code);
            check("sweep_key_pressed", key_pressed, 1'b1);
            check("sweep_columnas", columnas, vecs[i].exp_col);
            key_down = 1'b0;
            wait_release(40, cyc2, ok);
            check("sweep_release_seen", ok, 1'b1);
            check("sweep_next_col", columnas, vecs[i].exp_next_col);
            check("sweep_single_pulse", valid_cnt - v0, 1);
        end

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
